// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, counter width and the per-axis FSM state encoding.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 11;

  localparam int unsigned H_ACTIVE_DEF = 800;
  localparam int unsigned H_FP_DEF     = 40;
  localparam int unsigned H_SYNC_DEF   = 128;
  localparam int unsigned H_BP_DEF     = 88;

  localparam int unsigned V_ACTIVE_DEF = 600;
  localparam int unsigned V_FP_DEF     = 1;
  localparam int unsigned V_SYNC_DEF   = 4;
  localparam int unsigned V_BP_DEF     = 23;

  localparam bit SYNC_POL_DEF = 1'b1;

  typedef enum logic [1:0] {
    ACT  = 2'd0,
    FP   = 2'd1,
    SYNC = 2'd2,
    BP   = 2'd3
  } axis_state_e;

  // Last in-segment index for a segment of the given width.
  function automatic logic [CNT_W-1:0] last_idx(input int unsigned width);
    return CNT_W'(width - 1);
  endfunction

endpackage

// File: rtl/vga_axis_ctr.sv
// One timing axis: position counter, ACT/FP/SYNC/BP FSM, registered blank/sync flags and a wrap strobe.
module vga_axis_ctr
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE_W = H_ACTIVE_DEF,
  parameter int unsigned FP_W     = H_FP_DEF,
  parameter int unsigned SYNC_W   = H_SYNC_DEF,
  parameter int unsigned BP_W     = H_BP_DEF,
  parameter bit          SYNC_POL = SYNC_POL_DEF
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             blnk,
  output logic             sync,
  output logic             wrap_c
);

  axis_state_e      state;
  axis_state_e      state_nxt;
  logic [CNT_W-1:0] seg_cnt;
  logic [CNT_W-1:0] seg_cnt_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] seg_last;
  logic             seg_done;
  logic             blnk_nxt;
  logic             sync_nxt;

  // State, counters and flags advance together so flags stay aligned with count.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      state   <= ACT;
      seg_cnt <= '0;
      count   <= '0;
      blnk    <= 1'b0;
      sync    <= ~SYNC_POL;
    end else if (en) begin
      state   <= state_nxt;
      seg_cnt <= seg_cnt_nxt;
      count   <= count_nxt;
      blnk    <= blnk_nxt;
      sync    <= sync_nxt;
    end
  end

  // Segment sequencing; the position counter wraps exactly when BP finishes.
  always_comb begin
    state_nxt   = state;
    seg_cnt_nxt = seg_cnt + CNT_W'(1);
    count_nxt   = count + CNT_W'(1);
    wrap_c      = 1'b0;
    seg_last    = last_idx(ACTIVE_W);
    case (state)
      ACT:  seg_last = last_idx(ACTIVE_W);
      FP:   seg_last = last_idx(FP_W);
      SYNC: seg_last = last_idx(SYNC_W);
      BP:   seg_last = last_idx(BP_W);
    endcase
    seg_done = (seg_cnt == seg_last);
    if (seg_done) begin
      seg_cnt_nxt = '0;
      case (state)
        ACT:  state_nxt = FP;
        FP:   state_nxt = SYNC;
        SYNC: state_nxt = BP;
        BP: begin
          state_nxt = ACT;
          count_nxt = '0;
          wrap_c    = en;
        end
      endcase
    end
  end

  // Flags derived from the upcoming state, registered alongside it.
  always_comb begin
    blnk_nxt = (state_nxt != ACT);
    sync_nxt = (state_nxt == SYNC) ? SYNC_POL : ~SYNC_POL;
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: horizontal axis drives the vertical axis on each line wrap.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_POL = SYNC_POL_DEF
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             frame_start
);

  logic h_wrap_c;
  logic v_wrap_c;
  logic v_en_c;

  assign v_en_c = h_wrap_c & en;

  vga_axis_ctr #(
    .ACTIVE_W (H_ACTIVE),
    .FP_W     (H_FP),
    .SYNC_W   (H_SYNC),
    .BP_W     (H_BP),
    .SYNC_POL (SYNC_POL)
  ) u_h_axis (
    .pclk   (pclk),
    .rst    (rst),
    .en     (en),
    .count  (hcount),
    .blnk   (hblnk),
    .sync   (hsync),
    .wrap_c (h_wrap_c)
  );

  vga_axis_ctr #(
    .ACTIVE_W (V_ACTIVE),
    .FP_W     (V_FP),
    .SYNC_W   (V_SYNC),
    .BP_W     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_v_axis (
    .pclk   (pclk),
    .rst    (rst),
    .en     (v_en_c),
    .count  (vcount),
    .blnk   (vblnk),
    .sync   (vsync),
    .wrap_c (v_wrap_c)
  );

  // Pulses only on a real frame wrap, so the first frame after reset has none.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= h_wrap_c & v_wrap_c;
    end
  end

endmodule
